// File: rtl/dac_spi_pkg.sv
// Shared constants and types for the DAC SPI responder.
// Frame field positions, command codes and FSM states.
package dac_spi_pkg;

    localparam int FRAME_BITS = 32;
    localparam int CNT_W      = 6;

    localparam int CMD_MSB  = 27;
    localparam int CMD_LSB  = 24;
    localparam int ADDR_MSB = 23;
    localparam int ADDR_LSB = 20;
    localparam int CODE_MSB = 19;
    localparam int CODE_LSB = 8;
    localparam int REF_BIT  = 0;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    typedef enum logic [3:0] {
        CMD_WR_IN  = 4'h0,
        CMD_UPD    = 4'h1,
        CMD_WR_UPD = 4'h3,
        CMD_SETUP  = 4'h8
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/dac_spi_frame_shift.sv
// Frame deserialiser: shift register, bit counter and length check.
// len_err is only meaningful while the FSM is in SHIFT.
module dac_spi_frame_shift
    import dac_spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  mosi,
    input  logic                  shift_en,
    input  logic                  start,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_done,
    output logic                  len_err
);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Next shift/count: a start restarts the count at one captured bit.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (shift_en) begin
            shift_d = {shift_q[FRAME_BITS-2:0], mosi};
            cnt_d   = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end
    end

    // Shift register and bit counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign frame      = shift_q;
    assign frame_done = (cnt_q == CNT_W'(FRAME_BITS));
    // Early cs rise, or a bit beyond a full frame, is a length error.
    assign len_err    = cs ? !frame_done : frame_done;

endmodule

// File: rtl/dac_spi_rx.sv
// DAC-side SPI responder: frame FSM, command decode and
// per-channel input/output code registers.
module dac_spi_rx
    import dac_spi_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CODE_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     mosi,
    output logic                     ref_en,
    output logic [NUM_CH*CODE_W-1:0] dac_code,
    output logic [NUM_CH-1:0]        upd,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     cmd_err
);

    logic [FRAME_BITS-1:0] frame;
    logic                  frame_done;
    logic                  len_err;
    logic                  sh_en;
    logic                  sh_start;

    dac_spi_frame_shift u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .mosi       (mosi),
        .shift_en   (sh_en),
        .start      (sh_start),
        .frame      (frame),
        .frame_done (frame_done),
        .len_err    (len_err)
    );

    logic [3:0]        cmd;
    logic [3:0]        addr;
    logic [CODE_W-1:0] code;
    logic              addr_ok;
    logic              unused_bits;

    assign cmd         = frame[CMD_MSB:CMD_LSB];
    assign addr        = frame[ADDR_MSB:ADDR_LSB];
    assign code        = frame[CODE_MSB:CODE_LSB];
    assign addr_ok     = (addr == ADDR_ALL) ||
                         ({28'd0, addr} < 32'(NUM_CH));
    assign unused_bits = ^{frame[31:28], frame[7:1]};

    state_e                         state_q, state_d;
    logic [NUM_CH-1:0][CODE_W-1:0]  in_q, in_d;
    logic [NUM_CH-1:0][CODE_W-1:0]  dac_q, dac_d;
    logic                           ref_q, ref_d;
    logic [NUM_CH-1:0]              upd_q, upd_d;
    logic                           fv_q, fv_d;
    logic                           fe_q, fe_d;
    logic                           ce_q, ce_d;
    logic                           is_wr;
    logic                           is_upd;
    logic                           is_wr_upd;
    logic                           is_setup;
    logic                           sel;

    // Frame FSM and command execution into the register file.
    always_comb begin
        state_d   = state_q;
        in_d      = in_q;
        dac_d     = dac_q;
        ref_d     = ref_q;
        upd_d     = '0;
        fv_d      = 1'b0;
        fe_d      = 1'b0;
        ce_d      = 1'b0;
        sh_en     = 1'b0;
        sh_start  = 1'b0;
        sel       = 1'b0;
        is_wr     = (cmd == CMD_WR_IN);
        is_upd    = (cmd == CMD_UPD);
        is_wr_upd = (cmd == CMD_WR_UPD);
        is_setup  = (cmd == CMD_SETUP);
        unique case (state_q)
            ST_IDLE: begin
                if (!cs) begin
                    sh_en    = 1'b1;
                    sh_start = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (len_err) begin
                    fe_d    = 1'b1;
                    state_d = cs ? ST_IDLE : ST_DRAIN;
                end else if (cs) begin
                    state_d = ST_DECODE;
                end else begin
                    sh_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cs) state_d = ST_IDLE;
            end
            ST_DECODE: begin
                if (is_setup) begin
                    ref_d = frame[REF_BIT];
                    fv_d  = 1'b1;
                end else if ((is_wr || is_upd || is_wr_upd) && addr_ok) begin
                    fv_d = 1'b1;
                    for (int n = 0; n < NUM_CH; n++) begin
                        sel = (addr == ADDR_ALL) || (addr == 4'(n));
                        if (sel && (is_wr || is_wr_upd)) in_d[n] = code;
                        if (sel && is_upd) dac_d[n] = in_q[n];
                        if (sel && is_wr_upd) dac_d[n] = code;
                        if (sel && (is_upd || is_wr_upd)) upd_d[n] = 1'b1;
                    end
                end else begin
                    ce_d = 1'b1;
                end
                if (!cs) begin
                    sh_en    = 1'b1;
                    sh_start = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, register file and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            dac_q   <= '0;
            ref_q   <= 1'b0;
            upd_q   <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            dac_q   <= dac_d;
            ref_q   <= ref_d;
            upd_q   <= upd_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            ce_q    <= ce_d;
        end
    end

    assign ref_en      = ref_q;
    assign dac_code    = dac_q;
    assign upd         = upd_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign cmd_err     = ce_q;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Directed bench for dac_spi_rx: drives frames on negedge,
// samples on negedge, hand-computed expectations.
module tb_dac_spi_rx;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cs = 1'b1;
    logic                 mosi = 1'b0;
    logic                 ref_en;
    logic [7:0][11:0]     dac_code;
    logic [7:0]           upd;
    logic                 frame_valid;
    logic                 frame_err;
    logic                 cmd_err;

    int pass_cnt = 0;
    int tot_cnt = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    logic [7:0][11:0] exp_dac = '0;

    dac_spi_rx #(.NUM_CH(8), .CODE_W(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .mosi        (mosi),
        .ref_en      (ref_en),
        .dac_code    (dac_code),
        .upd         (upd),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .cmd_err     (cmd_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Pulse counters used to verify exact pulse counts.
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (frame_err) fe_cnt++;
    end

    // Hard stop in case anything stalls.
    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [39:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            cs = 1'b0;
            mosi = d[i];
        end
        @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cs = 1'b1;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if (ref_en !== 1'b0) $display("FAIL rst_ref: got %0b exp 0", ref_en);
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== '0) $display("FAIL rst_dac: got %h exp 0", dac_code);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h00) $display("FAIL rst_upd: got %h exp 00", upd);
        else pass_cnt++;
        tot_cnt++;
        if ({frame_valid, frame_err, cmd_err} !== 3'b000)
            $display("FAIL rst_pulses: got %b exp 000", {frame_valid, frame_err, cmd_err});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_setup();
        send({8'h00, 32'h08000001}, 32);
        @(negedge clk);
        tot_cnt++;
        if ({frame_valid, frame_err, cmd_err} !== 3'b000)
            $display("FAIL setup_early: got %b exp 000", {frame_valid, frame_err, cmd_err});
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({frame_valid, frame_err, cmd_err} !== 3'b100)
            $display("FAIL setup_pulse: got %b exp 100", {frame_valid, frame_err, cmd_err});
        else pass_cnt++;
        tot_cnt++;
        if (ref_en !== 1'b1) $display("FAIL setup_ref: got %0b exp 1", ref_en);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h00) $display("FAIL setup_upd: got %h exp 00", upd);
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL setup_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (frame_valid !== 1'b0) $display("FAIL setup_once: got %0b exp 0", frame_valid);
        else pass_cnt++;
    endtask

    task automatic test_wr_upd();
        send({8'h00, 32'h030ABC00}, 32);
        repeat (2) @(negedge clk);
        exp_dac[0] = 12'hABC;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL wrupd_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h01) $display("FAIL wrupd_upd: got %h exp 01", upd);
        else pass_cnt++;
        tot_cnt++;
        if (frame_valid !== 1'b1) $display("FAIL wrupd_fv: got %0b exp 1", frame_valid);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (upd !== 8'h00) $display("FAIL wrupd_upd_clr: got %h exp 00", upd);
        else pass_cnt++;
    endtask

    task automatic test_wr_then_upd();
        send({8'h00, 32'h00255500}, 32);
        repeat (2) @(negedge clk);
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL wrin_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h00) $display("FAIL wrin_upd: got %h exp 00", upd);
        else pass_cnt++;
        tot_cnt++;
        if (frame_valid !== 1'b1) $display("FAIL wrin_fv: got %0b exp 1", frame_valid);
        else pass_cnt++;
        send({8'h00, 32'h01200000}, 32);
        repeat (2) @(negedge clk);
        exp_dac[2] = 12'h555;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL upd_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h04) $display("FAIL upd_upd: got %h exp 04", upd);
        else pass_cnt++;
    endtask

    task automatic test_len_err();
        int fe0;
        int err_idx;
        logic [39:0] d;
        send({20'h0, 20'h03112}, 20);
        @(negedge clk);
        tot_cnt++;
        if ({frame_valid, frame_err, cmd_err} !== 3'b010)
            $display("FAIL short_err: got %b exp 010", {frame_valid, frame_err, cmd_err});
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (frame_err !== 1'b0) $display("FAIL short_once: got %0b exp 0", frame_err);
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL short_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        fe0 = fe_cnt;
        err_idx = -1;
        d = {32'h03112300, 8'hA5};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_err && err_idx < 0) err_idx = i;
            cs = 1'b0;
            mosi = d[39 - i];
        end
        @(negedge clk);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        tot_cnt++;
        if (err_idx !== 33) $display("FAIL long_err_pos: got %0d exp 33", err_idx);
        else pass_cnt++;
        tot_cnt++;
        if (fe_cnt - fe0 !== 1) $display("FAIL long_err_cnt: got %0d exp 1", fe_cnt - fe0);
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL long_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        send({8'h00, 32'h03112300}, 32);
        repeat (2) @(negedge clk);
        exp_dac[1] = 12'h123;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL after_err_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h02) $display("FAIL after_err_upd: got %h exp 02", upd);
        else pass_cnt++;
    endtask

    task automatic test_cmd_err();
        send({8'h00, 32'h0F000000}, 32);
        repeat (2) @(negedge clk);
        tot_cnt++;
        if ({frame_valid, frame_err, cmd_err} !== 3'b001)
            $display("FAIL badcmd: got %b exp 001", {frame_valid, frame_err, cmd_err});
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h00) $display("FAIL badcmd_upd: got %h exp 00", upd);
        else pass_cnt++;
        send({8'h00, 32'h03900100}, 32);
        repeat (2) @(negedge clk);
        tot_cnt++;
        if ({frame_valid, frame_err, cmd_err} !== 3'b001)
            $display("FAIL badaddr: got %b exp 001", {frame_valid, frame_err, cmd_err});
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL badaddr_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = fv_cnt;
        send({8'h00, 32'h03312300}, 32);
        send({8'h00, 32'h03434500}, 32);
        repeat (3) @(negedge clk);
        exp_dac[3] = 12'h123;
        exp_dac[4] = 12'h345;
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL b2b_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        tot_cnt++;
        if (fv_cnt - f0 !== 2) $display("FAIL b2b_fv_cnt: got %0d exp 2", fv_cnt - f0);
        else pass_cnt++;
    endtask

    task automatic test_broadcast();
        send({8'h00, 32'h03F7FF00}, 32);
        repeat (2) @(negedge clk);
        exp_dac = {8{12'h7FF}};
        tot_cnt++;
        if (dac_code !== exp_dac) $display("FAIL bcast_dac: got %h exp %h", dac_code, exp_dac);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'hFF) $display("FAIL bcast_upd: got %h exp FF", upd);
        else pass_cnt++;
        tot_cnt++;
        if (frame_valid !== 1'b1) $display("FAIL bcast_fv: got %0b exp 1", frame_valid);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int f0;
        int e0;
        logic [31:0] d;
        d = 32'h03512300;
        for (int i = 31; i >= 16; i--) begin
            @(negedge clk);
            cs = 1'b0;
            mosi = d[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tot_cnt++;
        if (ref_en !== 1'b0) $display("FAIL mrst_ref: got %0b exp 0", ref_en);
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== '0) $display("FAIL mrst_dac: got %h exp 0", dac_code);
        else pass_cnt++;
        tot_cnt++;
        if (upd !== 8'h00) $display("FAIL mrst_upd: got %h exp 00", upd);
        else pass_cnt++;
        cs = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        f0 = fv_cnt;
        e0 = fe_cnt;
        repeat (4) @(negedge clk);
        tot_cnt++;
        if ((fv_cnt - f0) + (fe_cnt - e0) !== 0)
            $display("FAIL mrst_pulses: got %0d exp 0", (fv_cnt - f0) + (fe_cnt - e0));
        else pass_cnt++;
        tot_cnt++;
        if (dac_code !== '0) $display("FAIL mrst_dac_after: got %h exp 0", dac_code);
        else pass_cnt++;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_setup();
        test_wr_upd();
        test_wr_then_upd();
        test_len_err();
        test_cmd_err();
        test_back_to_back();
        test_broadcast();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/dac_spi_rx.md
Name: dac_spi_rx

Overview:
- DAC-side SPI responder: the receiving end of the team's 32-bit DAC SPI link (`cs` active-low, `mosi` MSB-first, one bit per `clk`).
- Deserialises frames, checks frame length, decodes command/address/code, and maintains per-channel input and output code registers plus the internal-reference enable.
- Acts as a behavioural/synthesizable DAC model for closed-loop verification of the transmitter, and as a register front-end for an on-chip DAC.

Parameters:
- NUM_CH, 8, number of DAC channels (1..15); address 4'hF is broadcast.
- CODE_W, 12, DAC code width (fixed frame field [19:8]; must be 12).
- FRAME_BITS, 32, exact bits per valid frame.

Ports:
- clk  in  1  system clock; all sampling on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select, active low, synchronous to clk.
- mosi  in  1  serial data, sampled on posedge clk while cs==0.
- ref_en  out  1  internal reference enable.
- dac_code  out  NUM_CH*CODE_W  output (active) code per channel; channel n at [n*CODE_W +: CODE_W].
- upd  out  NUM_CH  one-cycle pulse per channel whose dac_code was loaded.
- frame_valid  out  1  one-cycle pulse: well-formed frame with legal cmd/addr executed.
- frame_err  out  1  one-cycle pulse: length error (bits != FRAME_BITS).
- cmd_err  out  1  one-cycle pulse: correct length, illegal cmd or addr.

Behaviour:
- Reset (async, rst_n=0): state IDLE; bit_cnt=0; shift_reg=0; all input_reg/dac_code=0; ref_en=0; upd=0; frame_valid=frame_err=cmd_err=0.
- Frame field map (shift_reg after 32 bits, first bit = [31]): [27:24] cmd, [23:20] addr, [19:8] code, [0] ref bit. Bits [31:28] and [7:1] are ignored.
- Commands:
  - 4'h0: input_reg[addr] <= code.
  - 4'h1: dac_code[addr] <= input_reg[addr]; upd[addr]=1.
  - 4'h3: input_reg and dac_code both <= code; upd=1.
  - 4'h8: ref_en <= frame[0]; addr ignored.
  - Any other cmd -> cmd_err; no state change.
- Address: addr < NUM_CH selects one channel. addr==4'hF applies to all channels, and upd asserts on all affected channels. Any other addr (cmd 0/1/3) -> cmd_err; no change.
- FSM states: IDLE, SHIFT, DECODE, DRAIN.
  - IDLE: cs==0 -> shift in mosi, bit_cnt=1, go SHIFT.
  - SHIFT, cs==0 and bit_cnt<32: shift left with mosi in LSB, bit_cnt++.
  - SHIFT, cs==0 and bit_cnt==32 (33rd bit): frame_err pulse, go DRAIN.
  - SHIFT, cs==1: if bit_cnt==32 go DECODE; else frame_err pulse, go IDLE.
  - DRAIN: ignore mosi until cs==1, then IDLE; no further error pulses.
  - DECODE: execute command; pulse frame_valid or cmd_err (and upd) for exactly this cycle. If cs==0 in DECODE, capture mosi as bit 1 of the next frame (bit_cnt=1, go SHIFT); else go IDLE.
- Latency: the last data bit is sampled at edge E. cs high is sampled at E+1. Registers and pulses are updated at E+2.
- Back-to-back frames require at least 1 cs-high cycle; a minimum gap is supported without loss.
- Outputs are registered. Pulses are mutually exclusive. upd is set only together with frame_valid.
- Reset deassertion while cs==0: the remaining partial frame is treated as a new frame and yields frame_err. No recovery is attempted.
- Reset mid-frame discards the frame and clears all registers.

Decomposition:
- Package dac_spi_pkg holds:
  - cmd enum (CMD_WR_IN=0, CMD_UPD=1, CMD_WR_UPD=3, CMD_SETUP=8);
  - FRAME_BITS;
  - field position constants;
  - ADDR_ALL=4'hF;
  - FSM state typedef.
- One sub-module, dac_spi_frame_shift, contains the shift register, bit counter and length check. It outputs frame[31:0], frame_done and len_err.
- The top level contains the FSM decode and the channel register file.

Test Plan:
- Setup frame 32'h08000001, then cs high -> ref_en=1 at E+2; frame_valid 1 cycle; upd=0; dac_code unchanged.
- Frame 32'h030ABC00 -> dac_code ch0=12'hABC; upd=8'h01; frame_valid pulse; other channels 0.
- 32'h00255500 then 32'h01200000 -> after first frame ch2 dac_code still 0 and upd=0; after second ch2=12'h555, upd=8'h04.
- Broadcast 32'h03F7FF00 -> all 8 channels = 12'h7FF; upd=8'hFF.
- Length errors: 20-bit frame -> frame_err at cs rise, no register change. 40-bit frame -> frame_err at bit 33, single pulse, DRAIN until cs high. Next valid frame executes normally.
- 32'h0F000000 -> cmd_err. 32'h03900100 (addr 9 with NUM_CH=8) -> cmd_err. rst_n low at bit 16 of a frame -> all outputs 0, no pulse.
